apb_mem_slave_param: RTL and testbench

//  Parametrised APB (v3-style) memory-mapped slave: word-addressed RAM of DEPTH x DATA_W,

---
 rtl/apb_mem_slave_param.sv | 166 ++++++++++++++++
 tb/tb_apb_mem_slave_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_param.sv
// apb_mem_slave_param: parametrised APB memory slave.
// Word-addressed RAM of DEPTH x DATA_W with WAIT_CYC fixed wait states per transfer.
// Accesses to addresses at or above DEPTH return pslverr=1 and never touch the RAM.
// Optional feature macro: APB_SLV_PSTRB_EN adds the pstrb port. With it, writes update
// only the strobed bytes, and a read with any strobe set is answered with an error.
module apb_mem_slave_param #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 256,
   parameter int WAIT_CYC = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
   input  logic [DATA_W/8-1:0] pstrb,
`endif
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr
);

   localparam int NB = DATA_W / 8;
   localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]       strb_q, strb_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic                pslverr_q, pslverr_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                setup, access, commit;
   logic [NB-1:0]       strb_in;
   logic                setup_err;
   logic                enter_done;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_write, rd_err;

   assign setup  = psel & ~penable;
   assign access = psel & penable;

`ifdef APB_SLV_PSTRB_EN
   assign strb_in   = pstrb;
   assign setup_err = ({1'b0, paddr} >= DEPTH_L) | (~pwrite & (|pstrb));
`else
   assign strb_in   = '1;
   assign setup_err = ({1'b0, paddr} >= DEPTH_L);
`endif

   // The RAM write happens at the edge that completes the access phase of a good write.
   assign commit = (state_q == S_DONE) & access & write_q & ~err_q;

   assign pready  = (state_q == S_DONE);
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

   // Next-state logic. When DONE is entered straight from setup, the response is taken
   // from the live bus, because the capture registers are only loaded at that same edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      err_d      = err_q;
      prdata_d   = prdata_q;
      pslverr_d  = pslverr_q;
      enter_done = 1'b0;
      rd_addr    = addr_q;
      rd_write   = write_q;
      rd_err     = err_q;
      case (state_q)
         S_IDLE: begin
            if (setup) begin
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
               strb_d  = strb_in;
               err_d   = setup_err;
               if (WAIT_CYC == 0) begin
                  state_d    = S_DONE;
                  enter_done = 1'b1;
                  rd_addr    = paddr;
                  rd_write   = pwrite;
                  rd_err     = setup_err;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!access) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d    = S_DONE;
               enter_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            pslverr_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_done) begin
         pslverr_d = rd_err;
         if (!rd_write) begin
            prdata_d = rd_err ? '0 : mem[rd_addr];
         end
      end
   end

   // Control and response registers; reset abandons any transfer in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   // RAM byte-lane write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (strb_q[b]) begin
               mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Bench for apb_mem_slave_param: two instances share the APB bus signals.
// dut_a: WAIT_CYC=0, DEPTH=200. dut_b: WAIT_CYC=3, DEPTH=256. Separate psel per instance.
module tb_apb_mem_slave_param;

   logic        clk;
   logic        rst;
   logic        psel_a, psel_b, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;

   int n_cmp = 0;
   int n_bad = 0;

   apb_mem_slave_param #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_CYC(0)) dut_a (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel_a),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb   (pstrb),
`endif
      .prdata  (prdata_a),
      .pready  (pready_a),
      .pslverr (pslverr_a)
   );

   apb_mem_slave_param #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_CYC(3)) dut_b (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel_b),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb   (pstrb),
`endif
      .prdata  (prdata_b),
      .pready  (pready_b),
      .pslverr (pslverr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One APB transfer. drop_at >= 0 releases psel at that access-cycle index.
   // After setup the bus address/data are scrambled so captured values are what count.
   task automatic apb_xfer(input logic b, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb, input int drop_at,
                           output logic [31:0] rd, output logic err, output int ncyc,
                           output logic rdy_seen);
      rd = '0;
      err = 1'b0;
      rdy_seen = 1'b0;
      @(posedge clk); #1;
      if (b) psel_b = 1'b1; else psel_a = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wd;
      pstrb   = strb;
      ncyc    = 1;
      @(posedge clk); #1;
      penable = 1'b1;
      paddr   = addr ^ 8'h03;
      pwdata  = ~wd;
      ncyc    = 2;
      for (int i = 0; i < 20; i++) begin
         if (i == drop_at) begin
            psel_a = 1'b0;
            psel_b = 1'b0;
            penable = 1'b0;
            break;
         end
         if (b ? pready_b : pready_a) begin
            rdy_seen = 1'b1;
            rd  = b ? prdata_b : prdata_a;
            err = b ? pslverr_b : pslverr_a;
            break;
         end
         @(posedge clk); #1;
         ncyc++;
      end
      if (rdy_seen) begin
         @(posedge clk); #1;
      end
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
      $display("xfer dut_%s %s addr=%h wd=%h strb=%b rd=%h err=%b cycles=%0d ready=%b",
               b ? "b" : "a", wr ? "WR" : "RD", addr, wd, strb, rd, err, ncyc, rdy_seen);
   endtask

   logic [31:0] rd;
   logic        err, rs;
   int          nc;

   initial begin
      rst = 1'b0;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      #12;
      check_eq("rst_prdata_a", prdata_a, 32'h0);
      check_eq("rst_pready_a", {31'b0, pready_a}, 32'h0);
      check_eq("rst_pslverr_a", {31'b0, pslverr_a}, 32'h0);
      check_eq("rst_prdata_b", prdata_b, 32'h0);
      rst = 1'b1;

      // Zero wait states: write then read, two cycles each.
      apb_xfer(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, -1, rd, err, nc, rs);
      check_eq("t1_wr_ready", {31'b0, rs}, 32'h1);
      check_eq("t1_wr_cycles", nc, 32'd2);
      check_eq("t1_wr_err", {31'b0, err}, 32'h0);
      apb_xfer(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t1_rd_cycles", nc, 32'd2);
      check_eq("t1_rd_data", rd, 32'hDEADBEEF);
      check_eq("t1_rd_err", {31'b0, err}, 32'h0);
      check_eq("t1_prdata_hold", prdata_a, 32'hDEADBEEF);

      // Three wait states: five cycles per transfer.
      apb_xfer(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, -1, rd, err, nc, rs);
      check_eq("t2_wr_cycles", nc, 32'd5);
      apb_xfer(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t2_rd_ready", {31'b0, rs}, 32'h1);
      check_eq("t2_rd_cycles", nc, 32'd5);
      check_eq("t2_rd_data", rd, 32'hDEADBEEF);

      // Out-of-range on DEPTH=200: no aliasing onto 0x48.
      apb_xfer(1'b0, 1'b1, 8'h48, 32'h11111111, 4'hF, -1, rd, err, nc, rs);
      apb_xfer(1'b0, 1'b1, 8'hC8, 32'h00000055, 4'hF, -1, rd, err, nc, rs);
      check_eq("t3_wr_oor_ready", {31'b0, rs}, 32'h1);
      check_eq("t3_wr_oor_err", {31'b0, err}, 32'h1);
      check_eq("t3_err_clears", {31'b0, pslverr_a}, 32'h0);
      apb_xfer(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, -1, rd, err, nc, rs);
      apb_xfer(1'b0, 1'b0, 8'hC8, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t3_rd_oor_err", {31'b0, err}, 32'h1);
      check_eq("t3_rd_oor_data", rd, 32'h0);
      apb_xfer(1'b0, 1'b0, 8'h48, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t3_rd_48_data", rd, 32'h11111111);
      check_eq("t3_rd_48_err", {31'b0, err}, 32'h0);

      // Abort in the first wait cycle: no response, no write.
      apb_xfer(1'b1, 1'b1, 8'h05, 32'h0BADF00D, 4'hF, -1, rd, err, nc, rs);
      apb_xfer(1'b1, 1'b1, 8'h05, 32'h00001234, 4'hF, 0, rd, err, nc, rs);
      check_eq("t4_no_ready", {31'b0, rs}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("t4_pready_low", {31'b0, pready_b}, 32'h0);
      end
      apb_xfer(1'b1, 1'b0, 8'h05, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t4_rd_prior", rd, 32'h0BADF00D);

      // Reset in the middle of a write's wait states.
      apb_xfer(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t5_pre_prdata", prdata_b, 32'hDEADBEEF);
      @(posedge clk); #1;
      psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hCAFEF00D;
      pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_eq("t5_prdata", prdata_b, 32'h0);
      check_eq("t5_pready", {31'b0, pready_b}, 32'h0);
      check_eq("t5_pslverr", {31'b0, pslverr_b}, 32'h0);
      check_eq("t5_prdata_a", prdata_a, 32'h0);
      psel_b = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      apb_xfer(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t5_not_committed", rd, 32'hDEADBEEF);

`ifdef APB_SLV_PSTRB_EN
      // Byte strobes on writes; strobes on reads are an error.
      apb_xfer(1'b1, 1'b1, 8'h01, 32'h11223344, 4'hF, -1, rd, err, nc, rs);
      apb_xfer(1'b1, 1'b1, 8'h01, 32'hAABBCCDD, 4'b0101, -1, rd, err, nc, rs);
      apb_xfer(1'b1, 1'b0, 8'h01, 32'h0, 4'h0, -1, rd, err, nc, rs);
      check_eq("t6_merge", rd, 32'h11BB33DD);
      apb_xfer(1'b1, 1'b0, 8'h01, 32'h0, 4'h1, -1, rd, err, nc, rs);
      check_eq("t6_rd_strb_err", {31'b0, err}, 32'h1);
      check_eq("t6_rd_strb_data", rd, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
